// File: rtl/square_lut_pipe.sv
// rtl/square_lut_pipe.sv - two-stage squaring lookup with valid/ready flow control and tag passthrough
module square_lut_pipe #(
  parameter int N_WIDTH = 4,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_WIDTH-1:0]   in_n,
  input  logic                 in_sign,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*N_WIDTH-1:0] out_square,
  output logic                 out_neg,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int SQ_W  = 2 * N_WIDTH;
  localparam int DEPTH = 1 << N_WIDTH;

  logic [SQ_W-1:0] sq_table [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_table
    assign sq_table[k] = SQ_W'(k * k);
  end

  logic               s1_valid;
  logic               s1_neg;
  logic [N_WIDTH-1:0] s1_mag;
  logic [TAG_W-1:0]   s1_tag;
  logic               s2_valid;
  logic               adv1;
  logic               adv2;
  logic               in_neg;
  logic [N_WIDTH-1:0] in_mag;

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // The most-negative code negates to itself in N bits, which read unsigned is
  // exactly its magnitude 2^(N_WIDTH-1), so no extra bit has to be carried.
  assign in_neg = in_sign & in_n[N_WIDTH-1];
  assign in_mag = in_neg ? (~in_n + N_WIDTH'(1)) : in_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_neg     <= 1'b0;
      s1_mag     <= '0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      out_square <= '0;
      out_neg    <= 1'b0;
      out_tag    <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        s1_neg   <= in_neg;
        s1_mag   <= in_mag;
        s1_tag   <= in_tag;
      end
      if (adv2) begin
        s2_valid   <= s1_valid;
        out_square <= sq_table[s1_mag];
        out_neg    <= s1_neg;
        out_tag    <= s1_tag;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_square_lut_pipe.sv
// tb/tb_square_lut_pipe.sv - scoreboard bench for square_lut_pipe at widths 4, 6 and 2
module tb_square_lut_pipe;

  logic clk;
  logic rst;

  logic       a_iv, a_ir, a_s, a_ov, a_or, a_neg;
  logic [3:0] a_n, a_tag, a_otag;
  logic [7:0] a_sq;

  logic        b_iv, b_ir, b_s, b_ov, b_or, b_neg;
  logic [5:0]  b_n;
  logic [7:0]  b_tag, b_otag;
  logic [11:0] b_sq;

  logic       c_iv, c_ir, c_s, c_ov, c_or, c_neg;
  logic [1:0] c_n;
  logic [3:0] c_tag, c_otag, c_sq;

  square_lut_pipe #(.N_WIDTH(4), .TAG_W(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_n(a_n), .in_sign(a_s),
    .in_tag(a_tag), .out_valid(a_ov), .out_ready(a_or), .out_square(a_sq), .out_neg(a_neg),
    .out_tag(a_otag));

  square_lut_pipe #(.N_WIDTH(6), .TAG_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_n(b_n), .in_sign(b_s),
    .in_tag(b_tag), .out_valid(b_ov), .out_ready(b_or), .out_square(b_sq), .out_neg(b_neg),
    .out_tag(b_otag));

  square_lut_pipe #(.N_WIDTH(2), .TAG_W(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_n(c_n), .in_sign(c_s),
    .in_tag(c_tag), .out_valid(c_ov), .out_ready(c_or), .out_square(c_sq), .out_neg(c_neg),
    .out_tag(c_otag));

  typedef struct {
    int sq;
    int neg;
    int tag;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int   a_log[$], b_log[$], c_log[$];
  int   checks = 0;
  int   failures = 0;
  int   a_stalls = 0;
  bit   b_run;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Square of the operand read as w-bit unsigned or two's-complement signed.
  function automatic int model_sq(input int n, input int w, input bit s);
    int v;
    v = (s && ((n >> (w - 1)) & 1) == 1) ? n - (1 << w) : n;
    return v * v;
  endfunction

  function automatic int model_neg(input int n, input int w, input bit s);
    return (s && ((n >> (w - 1)) & 1) == 1) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      qc.delete();
    end else begin
      if (qa.size() == 0) chk("a_valid_when_empty", a_ov, 0);
      else if (a_ov) begin
        chk("a_square", a_sq, qa[0].sq);
        chk("a_neg", a_neg, qa[0].neg);
        chk("a_tag", a_otag, qa[0].tag);
        if (a_or) begin a_log.push_back(int'(a_sq)); void'(qa.pop_front()); end
      end
      if (a_iv && a_ir) begin
        ea.sq = model_sq(int'(a_n), 4, a_s); ea.neg = model_neg(int'(a_n), 4, a_s);
        ea.tag = int'(a_tag); qa.push_back(ea);
      end

      if (qb.size() == 0) chk("b_valid_when_empty", b_ov, 0);
      else if (b_ov) begin
        chk("b_square", b_sq, qb[0].sq);
        chk("b_neg", b_neg, qb[0].neg);
        chk("b_tag", b_otag, qb[0].tag);
        if (b_or) begin b_log.push_back(int'(b_sq)); void'(qb.pop_front()); end
      end
      if (b_iv && b_ir) begin
        eb.sq = model_sq(int'(b_n), 6, b_s); eb.neg = model_neg(int'(b_n), 6, b_s);
        eb.tag = int'(b_tag); qb.push_back(eb);
      end

      if (qc.size() == 0) chk("c_valid_when_empty", c_ov, 0);
      else if (c_ov) begin
        chk("c_square", c_sq, qc[0].sq);
        chk("c_neg", c_neg, qc[0].neg);
        chk("c_tag", c_otag, qc[0].tag);
        if (c_or) begin c_log.push_back(int'(c_sq)); void'(qc.pop_front()); end
      end
      if (c_iv && c_ir) begin
        ec.sq = model_sq(int'(c_n), 2, c_s); ec.neg = model_neg(int'(c_n), 2, c_s);
        ec.tag = int'(c_tag); qc.push_back(ec);
      end
    end
  end

  task automatic push_a(input int n, input bit s, input int tag);
    bit acc;
    a_iv = 1'b1; a_n = 4'(n); a_s = s; a_tag = 4'(tag);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); acc = a_ir;
      @(posedge clk); #1;
      if (acc) begin a_iv = 1'b0; return; end
      a_stalls++;
    end
    chk("a_push_timeout", 0, 1);
  endtask

  task automatic push_b(input int n, input bit s, input int tag);
    bit acc;
    b_iv = 1'b1; b_n = 6'(n); b_s = s; b_tag = 8'(tag);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); acc = b_ir;
      @(posedge clk); #1;
      if (acc) begin b_iv = 1'b0; return; end
    end
    chk("b_push_timeout", 0, 1);
  endtask

  task automatic push_c(input int n, input bit s, input int tag);
    bit acc;
    c_iv = 1'b1; c_n = 2'(n); c_s = s; c_tag = 4'(tag);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); acc = c_ir;
      @(posedge clk); #1;
      if (acc) begin c_iv = 1'b0; return; end
    end
    chk("c_push_timeout", 0, 1);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 100 && qa.size() != 0; i++) begin @(posedge clk); #1; end
    chk("a_drained", qa.size(), 0);
  endtask

  initial begin
    int base;
    int sgn_exp[16] = '{64, 49, 36, 25, 16, 9, 4, 1, 0, 1, 4, 9, 16, 25, 36, 49};
    int bp_exp[5]   = '{9, 25, 49, 81, 121};
    int c_exp[5]    = '{4, 1, 0, 1, 9};

    rst = 1'b1;
    a_iv = 0; a_n = 0; a_s = 0; a_tag = 0; a_or = 1;
    b_iv = 0; b_n = 0; b_s = 0; b_tag = 0; b_or = 1;
    c_iv = 0; c_n = 0; c_s = 0; c_tag = 0; c_or = 1;

    chk("model_s4_m8", model_sq(8, 4, 1), 64);
    chk("model_u4_15", model_sq(15, 4, 0), 225);
    chk("model_s6_m32", model_sq(32, 6, 1), 1024);
    chk("model_u6_63", model_sq(63, 6, 0), 3969);
    chk("model_s2_m2", model_sq(2, 2, 1), 4);

    #3;
    chk("rst_a_out_valid", a_ov, 0);
    chk("rst_a_square", a_sq, 0);
    chk("rst_a_neg", a_neg, 0);
    chk("rst_a_tag", a_otag, 0);
    chk("rst_a_in_ready", a_ir, 1);
    chk("rst_b_in_ready", b_ir, 1);
    chk("rst_c_out_valid", c_ov, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // unsigned sweep, back-to-back; checks 2-cycle latency and no stalls
    base = a_log.size();
    a_stalls = 0;
    push_a(0, 0, 0);
    chk("lat_not_yet_valid", a_ov, 0);
    push_a(1, 0, 1);
    chk("lat_valid_after_t1", a_ov, 1);
    chk("lat_first_square", a_sq, 0);
    for (int k = 2; k < 16; k++) push_a(k, 0, k);
    chk("u_sweep_no_stalls", a_stalls, 0);
    drain_a();
    for (int k = 0; k < 16; k++) chk("u_sweep_result", a_log[base + k], k * k);
    chk("u_sweep_top", a_log[base + 15], 225);

    // signed sweep 0x8..0x7
    base = a_log.size();
    for (int k = 0; k < 16; k++) push_a((k + 8) % 16, 1, k);
    drain_a();
    for (int k = 0; k < 16; k++) chk("s_sweep_result", a_log[base + k], sgn_exp[k]);

    // backpressure: two accepts fill the pipe, third is held off
    base = a_log.size();
    a_or = 1'b0;
    push_a(3, 0, 1);
    push_a(5, 0, 2);
    a_iv = 1'b1; a_n = 4'd7; a_s = 1'b0; a_tag = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready_low", a_ir, 0);
      chk("bp_out_valid", a_ov, 1);
      chk("bp_held_square", a_sq, 9);
      chk("bp_held_tag", a_otag, 1);
    end
    @(posedge clk); #1;
    a_or = 1'b1;
    #1 chk("bp_release_same_cycle_ready", a_ir, 1);
    push_a(7, 0, 3);
    push_a(9, 0, 4);
    push_a(11, 0, 5);
    drain_a();
    chk("bp_result_count", a_log.size() - base, 5);
    for (int k = 0; k < 5; k++) chk("bp_result", a_log[base + k], bp_exp[k]);

    // asynchronous reset with two results in flight
    a_or = 1'b0;
    push_a(1, 0, 6);
    push_a(2, 0, 7);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", a_ov, 0);
    chk("mid_rst_square", a_sq, 0);
    chk("mid_rst_in_ready", a_ir, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    a_or = 1'b1;
    base = a_log.size();
    repeat (4) @(posedge clk);
    #1 chk("no_stale_after_rst", a_log.size() - base, 0);
    push_a(3, 0, 8);
    chk("post_rst_not_yet", a_ov, 0);
    @(posedge clk); #1;
    chk("post_rst_valid", a_ov, 1);
    chk("post_rst_square", a_sq, 9);
    drain_a();

    // N_WIDTH=2 corner
    push_c(2, 1, 0);
    push_c(3, 1, 1);
    push_c(0, 1, 2);
    push_c(1, 1, 3);
    push_c(3, 0, 4);
    for (int i = 0; i < 100 && qc.size() != 0; i++) begin @(posedge clk); #1; end
    chk("c_drained", qc.size(), 0);
    chk("c_result_count", c_log.size(), 5);
    for (int k = 0; k < 5 && k < c_log.size(); k++) chk("c_result", c_log[k], c_exp[k]);

    // random valid/ready at N_WIDTH=6, TAG_W=8
    b_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          while ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
          if (i == 0) push_b(32, 1, 8'hA5);
          else if (i == 1) push_b(63, 0, 8'h5A);
          else push_b($urandom_range(0, 63), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
        end
        for (int i = 0; i < 1000 && qb.size() != 0; i++) begin @(posedge clk); #1; end
        b_run = 1'b0;
      end
      begin
        while (b_run) begin
          @(posedge clk); #1;
          b_or = 1'($urandom_range(0, 1));
        end
        b_or = 1'b1;
      end
    join
    chk("b_drained", qb.size(), 0);
    chk("b_result_count", b_log.size(), 10000);
    if (b_log.size() >= 2) begin
      chk("b_boundary_m32", b_log[0], 1024);
      chk("b_boundary_u63", b_log[1], 3969);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
